// File: rtl/atm_session_ctrl.sv
// Single-session ATM controller: account table, card lookup, PIN check with lockout,
// balance/withdraw/transfer commands and inactivity timeout, reported via a response strobe.
module atm_session_ctrl #(
    parameter int NUM_ACC   = 10,
    parameter int ACC_W     = 12,
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 16,
    parameter int AMT_W     = 11,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 255,
    localparam int IDX_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prov_we,
    input  logic [IDX_W-1:0] prov_idx,
    input  logic [ACC_W-1:0] prov_acc,
    input  logic [PIN_W-1:0] prov_pin,
    input  logic [BAL_W-1:0] prov_bal,
    input  logic             card_valid,
    input  logic [ACC_W-1:0] acc_num,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] amount,
    input  logic [ACC_W-1:0] dest_acc,
    output logic             busy,
    output logic             rsp_valid,
    output logic [2:0]       rsp_status,
    output logic [BAL_W-1:0] rsp_balance,
    output logic             session_active
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NO_ACC   = 3'd1;
    localparam logic [2:0] ST_BAD_PIN  = 3'd2;
    localparam logic [2:0] ST_LOCKED   = 3'd3;
    localparam logic [2:0] ST_INSUFF   = 3'd4;
    localparam logic [2:0] ST_NO_DEST  = 3'd5;
    localparam logic [2:0] ST_OVERFLOW = 3'd6;
    localparam logic [2:0] ST_TIMEOUT  = 3'd7;

    localparam logic [1:0] OP_BALANCE  = 2'd0;
    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_TRANSFER = 2'd2;
    localparam logic [1:0] OP_EXIT     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_PIN_WAIT, S_MENU, S_SCAN_DEST, S_EXEC
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0]   acc_tbl [NUM_ACC];
    logic [PIN_W-1:0]   pin_tbl [NUM_ACC];
    logic [BAL_W-1:0]   bal_tbl [NUM_ACC];
    logic [NUM_ACC-1:0] ent_vld, ent_lock;
    logic [TRY_W-1:0]   tries [NUM_ACC];

    logic [IDX_W-1:0] scan_idx, scan_idx_nxt;
    logic [IDX_W-1:0] cur_idx, cur_idx_nxt;
    logic [IDX_W-1:0] dest_idx, dest_idx_nxt;
    logic [ACC_W-1:0] scan_key;
    logic [AMT_W-1:0] amt_q;
    logic             is_xfer, is_xfer_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;

    logic             rsp_valid_nxt;
    logic [2:0]       rsp_status_nxt;
    logic [BAL_W-1:0] rsp_bal_nxt;

    logic prov_wr, key_ld_card, key_ld_dest, amt_ld;
    logic pin_ok, pin_bad, lock_set, exec_wr;
    logic scan_hit, scan_last, tmr_exp, prov_in_range;
    logic [BAL_W-1:0] cur_bal, dst_bal, amt_bal;

    // Carry out of a BAL_W+1 bit add flags a credit that would not fit the balance.
    function automatic logic add_overflows(input logic [BAL_W-1:0] a, input logic [BAL_W-1:0] b);
        logic [BAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BAL_W];
    endfunction

    assign cur_bal       = bal_tbl[cur_idx];
    assign dst_bal       = bal_tbl[dest_idx];
    assign amt_bal       = BAL_W'(amt_q);
    assign scan_hit      = ent_vld[scan_idx] && (acc_tbl[scan_idx] == scan_key);
    assign scan_last     = (int'(scan_idx) >= NUM_ACC - 1);
    assign tmr_exp       = (int'(tmr) >= TIMEOUT - 1);
    assign prov_in_range = (int'(prov_idx) < NUM_ACC);

    assign busy           = (state == S_SCAN) || (state == S_SCAN_DEST) || (state == S_EXEC);
    assign session_active = (state == S_MENU) || (state == S_SCAN_DEST) || (state == S_EXEC);

    always_comb begin
        state_nxt      = state;
        scan_idx_nxt   = scan_idx;
        cur_idx_nxt    = cur_idx;
        dest_idx_nxt   = dest_idx;
        is_xfer_nxt    = is_xfer;
        tmr_nxt        = tmr;
        rsp_valid_nxt  = 1'b0;
        rsp_status_nxt = ST_OK;
        rsp_bal_nxt    = '0;
        prov_wr        = 1'b0;
        key_ld_card    = 1'b0;
        key_ld_dest    = 1'b0;
        amt_ld         = 1'b0;
        pin_ok         = 1'b0;
        pin_bad        = 1'b0;
        lock_set       = 1'b0;
        exec_wr        = 1'b0;

        case (state)
            S_IDLE: begin
                if (prov_we) begin
                    prov_wr = prov_in_range;
                end else if (card_valid) begin
                    key_ld_card  = 1'b1;
                    scan_idx_nxt = '0;
                    state_nxt    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_hit) begin
                    if (ent_lock[scan_idx]) begin
                        rsp_valid_nxt  = 1'b1;
                        rsp_status_nxt = ST_LOCKED;
                        state_nxt      = S_IDLE;
                    end else begin
                        cur_idx_nxt = scan_idx;
                        tmr_nxt     = '0;
                        state_nxt   = S_PIN_WAIT;
                    end
                end else if (scan_last) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = ST_NO_ACC;
                    state_nxt      = S_IDLE;
                end else begin
                    scan_idx_nxt = scan_idx + IDX_W'(1);
                end
            end
            S_PIN_WAIT: begin
                if (pin_valid) begin
                    tmr_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                    if (pin == pin_tbl[cur_idx]) begin
                        pin_ok         = 1'b1;
                        rsp_status_nxt = ST_OK;
                        rsp_bal_nxt    = cur_bal;
                        state_nxt      = S_MENU;
                    end else if (int'(tries[cur_idx]) + 1 >= MAX_TRIES) begin
                        pin_bad        = 1'b1;
                        lock_set       = 1'b1;
                        rsp_status_nxt = ST_LOCKED;
                        state_nxt      = S_IDLE;
                    end else begin
                        pin_bad        = 1'b1;
                        rsp_status_nxt = ST_BAD_PIN;
                    end
                end else if (tmr_exp) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = ST_TIMEOUT;
                    state_nxt      = S_IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_MENU: begin
                if (cmd_valid) begin
                    tmr_nxt = '0;
                    case (cmd_op)
                        OP_BALANCE: begin
                            rsp_valid_nxt = 1'b1;
                            rsp_bal_nxt   = cur_bal;
                        end
                        OP_WITHDRAW: begin
                            amt_ld      = 1'b1;
                            is_xfer_nxt = 1'b0;
                            state_nxt   = S_EXEC;
                        end
                        OP_TRANSFER: begin
                            amt_ld       = 1'b1;
                            key_ld_dest  = 1'b1;
                            is_xfer_nxt  = 1'b1;
                            scan_idx_nxt = '0;
                            state_nxt    = S_SCAN_DEST;
                        end
                        OP_EXIT: begin
                            rsp_valid_nxt = 1'b1;
                            rsp_bal_nxt   = cur_bal;
                            state_nxt     = S_IDLE;
                        end
                    endcase
                end else if (tmr_exp) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = ST_TIMEOUT;
                    rsp_bal_nxt    = cur_bal;
                    state_nxt      = S_IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_SCAN_DEST: begin
                // The lowest matching index decides, so hitting our own entry first ends the scan.
                if (scan_hit && (scan_idx != cur_idx)) begin
                    dest_idx_nxt = scan_idx;
                    state_nxt    = S_EXEC;
                end else if (scan_hit || scan_last) begin
                    rsp_valid_nxt  = 1'b1;
                    rsp_status_nxt = ST_NO_DEST;
                    rsp_bal_nxt    = cur_bal;
                    tmr_nxt        = '0;
                    state_nxt      = S_MENU;
                end else begin
                    scan_idx_nxt = scan_idx + IDX_W'(1);
                end
            end
            S_EXEC: begin
                rsp_valid_nxt = 1'b1;
                tmr_nxt       = '0;
                state_nxt     = S_MENU;
                if (amt_bal > cur_bal) begin
                    rsp_status_nxt = ST_INSUFF;
                    rsp_bal_nxt    = cur_bal;
                end else if (is_xfer && add_overflows(dst_bal, amt_bal)) begin
                    rsp_status_nxt = ST_OVERFLOW;
                    rsp_bal_nxt    = cur_bal;
                end else begin
                    exec_wr        = 1'b1;
                    rsp_status_nxt = ST_OK;
                    rsp_bal_nxt    = cur_bal - amt_bal;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            scan_idx    <= '0;
            cur_idx     <= '0;
            dest_idx    <= '0;
            is_xfer     <= 1'b0;
            tmr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            ent_vld     <= '0;
            ent_lock    <= '0;
            for (int k = 0; k < NUM_ACC; k++) tries[k] <= '0;
        end else begin
            state       <= state_nxt;
            scan_idx    <= scan_idx_nxt;
            cur_idx     <= cur_idx_nxt;
            dest_idx    <= dest_idx_nxt;
            is_xfer     <= is_xfer_nxt;
            tmr         <= tmr_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_status  <= rsp_status_nxt;
            rsp_balance <= rsp_bal_nxt;
            if (prov_wr) begin
                ent_vld[prov_idx]  <= 1'b1;
                ent_lock[prov_idx] <= 1'b0;
                tries[prov_idx]    <= '0;
            end
            if (pin_ok) tries[cur_idx] <= '0;
            if (pin_bad) tries[cur_idx] <= tries[cur_idx] + TRY_W'(1);
            if (lock_set) ent_lock[cur_idx] <= 1'b1;
        end
    end

    // Table contents and latched operands carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (prov_wr) begin
            acc_tbl[prov_idx] <= prov_acc;
            pin_tbl[prov_idx] <= prov_pin;
            bal_tbl[prov_idx] <= prov_bal;
        end
        if (exec_wr) begin
            bal_tbl[cur_idx] <= cur_bal - amt_bal;
            if (is_xfer) bal_tbl[dest_idx] <= dst_bal + amt_bal;
        end
        if (key_ld_card) scan_key <= acc_num;
        else if (key_ld_dest) scan_key <= dest_acc;
        if (amt_ld) amt_q <= amount;
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus random sessions against an
// account-level reference model (lookup, PIN rules and balances in plain arithmetic).
module tb_atm_session_ctrl;
    localparam int NUM_ACC   = 10;
    localparam int ACC_W     = 12;
    localparam int PIN_W     = 4;
    localparam int BAL_W     = 16;
    localparam int AMT_W     = 11;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 255;
    localparam int IDX_W     = 4;

    localparam int OK = 0, NO_ACC = 1, BAD_PIN = 2, LOCKED = 3;
    localparam int INSUFF = 4, NO_DEST = 5, OVERFLOW = 6, TIMED_OUT = 7;
    localparam int BALANCE = 0, WITHDRAW = 1, TRANSFER = 2, EXIT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             prov_we;
    logic [IDX_W-1:0] prov_idx;
    logic [ACC_W-1:0] prov_acc;
    logic [PIN_W-1:0] prov_pin;
    logic [BAL_W-1:0] prov_bal;
    logic             card_valid;
    logic [ACC_W-1:0] acc_num;
    logic             pin_valid;
    logic [PIN_W-1:0] pin;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [AMT_W-1:0] amount;
    logic [ACC_W-1:0] dest_acc;
    logic             busy;
    logic             rsp_valid;
    logic [2:0]       rsp_status;
    logic [BAL_W-1:0] rsp_balance;
    logic             session_active;

    always #5 clk = ~clk;

    atm_session_ctrl #(
        .NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
        .AMT_W(AMT_W), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .prov_we(prov_we), .prov_idx(prov_idx), .prov_acc(prov_acc),
        .prov_pin(prov_pin), .prov_bal(prov_bal),
        .card_valid(card_valid), .acc_num(acc_num),
        .pin_valid(pin_valid), .pin(pin),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .amount(amount), .dest_acc(dest_acc),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .session_active(session_active)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: account table and abstract session phase (0 idle, 1 awaiting PIN, 2 logged in).
    int m_acc [NUM_ACC];
    int m_pin [NUM_ACC];
    int m_bal [NUM_ACC];
    bit m_vld [NUM_ACC];
    bit m_lock [NUM_ACC];
    int m_tries [NUM_ACC];
    int m_phase = 0;
    int m_cur = 0;

    function automatic int m_lookup(input int acc);
        for (int i = 0; i < NUM_ACC; i++)
            if (m_vld[i] && m_acc[i] == (acc & ((1 << ACC_W) - 1))) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ACC; i++) begin
            m_vld[i] = 0; m_lock[i] = 0; m_tries[i] = 0;
        end
        m_phase = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        prov_we = 0; card_valid = 0; pin_valid = 0; cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int maxc, output int lat, output int st, output int bal);
        lat = 0; st = -1; bal = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            clear_strobes();
            if (rsp_valid) begin
                lat = i; st = int'(rsp_status); bal = int'(rsp_balance);
                break;
            end
        end
    endtask

    task automatic prov(input int idx, input int acc, input int p, input int bal);
        prov_we = 1; prov_idx = IDX_W'(idx); prov_acc = ACC_W'(acc);
        prov_pin = PIN_W'(p); prov_bal = BAL_W'(bal);
        step();
        clear_strobes();
        m_acc[idx] = acc & ((1 << ACC_W) - 1); m_pin[idx] = p; m_bal[idx] = bal;
        m_vld[idx] = 1; m_lock[idx] = 0; m_tries[idx] = 0;
    endtask

    task automatic do_card(input int acc);
        int idx, exp_steps, steps, exp_st, st, bal;
        logic exp_rv, rv;
        idx = m_lookup(acc);
        if (idx < 0) begin
            exp_steps = NUM_ACC + 1; exp_rv = 1; exp_st = NO_ACC;
        end else if (m_lock[idx]) begin
            exp_steps = idx + 2; exp_rv = 1; exp_st = LOCKED;
        end else begin
            exp_steps = idx + 2; exp_rv = 0; exp_st = 0;
        end
        card_valid = 1; acc_num = ACC_W'(acc);
        steps = 0; rv = 0; st = 0; bal = 0;
        for (int i = 1; i <= NUM_ACC + 3; i++) begin
            step();
            clear_strobes();
            if (rsp_valid) begin
                rv = 1; st = int'(rsp_status); bal = int'(rsp_balance);
            end
            if (!busy) begin
                steps = i;
                break;
            end
        end
        n_total++;
        if (steps !== exp_steps || rv !== exp_rv || st !== exp_st || bal !== 0)
            $display("FAIL card %0d: steps=%0d rsp=%0b status=%0d bal=%0d, expected steps=%0d rsp=%0b status=%0d bal=0",
                     acc, steps, rv, st, bal, exp_steps, exp_rv, exp_st);
        else
            n_pass++;
        if (idx >= 0 && !m_lock[idx]) begin
            m_phase = 1; m_cur = idx;
        end
    endtask

    task automatic do_pin(input int p);
        int exp_st, exp_bal, lat, st, bal;
        if (p == m_pin[m_cur]) begin
            exp_st = OK; exp_bal = m_bal[m_cur]; m_tries[m_cur] = 0; m_phase = 2;
        end else begin
            m_tries[m_cur]++;
            exp_bal = 0;
            if (m_tries[m_cur] >= MAX_TRIES) begin
                m_lock[m_cur] = 1; exp_st = LOCKED; m_phase = 0;
            end else begin
                exp_st = BAD_PIN;
            end
        end
        pin_valid = 1; pin = PIN_W'(p);
        wait_rsp(3, lat, st, bal);
        n_total++;
        if (lat !== 1 || st !== exp_st || bal !== exp_bal)
            $display("FAIL pin %0d: latency=%0d status=%0d bal=%0d, expected latency=1 status=%0d bal=%0d",
                     p, lat, st, bal, exp_st, exp_bal);
        else
            n_pass++;
    endtask

    task automatic do_cmd(input int op, input int amt, input int dest);
        int exp_lat, exp_st, exp_bal, j, b, lat, st, bal;
        b = m_bal[m_cur]; exp_lat = 1; exp_st = OK; exp_bal = b;
        case (op)
            EXIT: m_phase = 0;
            WITHDRAW: begin
                exp_lat = 2;
                if (amt > b) exp_st = INSUFF;
                else begin
                    m_bal[m_cur] = b - amt; exp_bal = b - amt;
                end
            end
            TRANSFER: begin
                j = m_lookup(dest);
                if (j < 0) begin
                    exp_lat = NUM_ACC + 1; exp_st = NO_DEST;
                end else if (j == m_cur) begin
                    exp_lat = j + 2; exp_st = NO_DEST;
                end else begin
                    exp_lat = j + 3;
                    if (amt > b) exp_st = INSUFF;
                    else if (m_bal[j] + amt > (1 << BAL_W) - 1) exp_st = OVERFLOW;
                    else begin
                        m_bal[m_cur] = b - amt; m_bal[j] = m_bal[j] + amt; exp_bal = b - amt;
                    end
                end
            end
            default: ;
        endcase
        cmd_valid = 1; cmd_op = 2'(op); amount = AMT_W'(amt); dest_acc = ACC_W'(dest);
        wait_rsp(NUM_ACC + 5, lat, st, bal);
        n_total++;
        if (lat !== exp_lat || st !== exp_st || bal !== exp_bal)
            $display("FAIL cmd op=%0d amt=%0d dest=%0d: latency=%0d status=%0d bal=%0d, expected latency=%0d status=%0d bal=%0d",
                     op, amt, dest, lat, st, bal, exp_lat, exp_st, exp_bal);
        else
            n_pass++;
    endtask

    task automatic do_timeout();
        int exp_bal, lat, st, bal;
        exp_bal = (m_phase == 2) ? m_bal[m_cur] : 0;
        wait_rsp(TIMEOUT + 5, lat, st, bal);
        n_total++;
        if (lat !== TIMEOUT || st !== TIMED_OUT || bal !== exp_bal)
            $display("FAIL timeout: latency=%0d status=%0d bal=%0d, expected latency=%0d status=%0d bal=%0d",
                     lat, st, bal, TIMEOUT, TIMED_OUT, exp_bal);
        else
            n_pass++;
        m_phase = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_strobes();
        prov_idx = '0; prov_acc = '0; prov_pin = '0; prov_bal = '0;
        acc_num = '0; pin = '0; cmd_op = '0; amount = '0; dest_acc = '0;
        repeat (2) @(posedge clk);
        #2;
        n_total++;
        if ({busy, session_active, rsp_valid, rsp_status, rsp_balance} !== '0)
            $display("FAIL reset outputs: busy=%0b active=%0b rsp=%0b status=%0d bal=%0d, expected all 0",
                     busy, session_active, rsp_valid, rsp_status, rsp_balance);
        else
            n_pass++;
        rst_n = 1;
        model_reset();
        step();
    endtask

    task automatic test_login_balance();
        prov(0, 1000, 7, 1000);
        prov(3, 2125, 3, 500);
        prov(5, 777, 1, 65000);
        do_card(2125);
        do_pin(3);
        n_total++;
        if (session_active !== 1'b1 || busy !== 1'b0)
            $display("FAIL menu flags: active=%0b busy=%0b, expected active=1 busy=0", session_active, busy);
        else
            n_pass++;
        do_cmd(BALANCE, 0, 0);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_lockout();
        do_card(2125);
        do_pin(0);
        do_pin(1);
        do_pin(2);
        do_card(2125);
        prov(3, 2125, 3, 500);
        do_card(2125);
        do_pin(3);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_withdraw();
        do_card(2125);
        do_pin(3);
        do_cmd(WITHDRAW, 500, 0);
        do_cmd(WITHDRAW, 1, 0);
        do_cmd(WITHDRAW, 0, 0);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_transfer();
        prov(3, 2125, 3, 1000);
        do_card(2125);
        do_pin(3);
        do_cmd(TRANSFER, 600, 777);
        do_cmd(TRANSFER, 50, 2125);
        do_cmd(TRANSFER, 50, 9999);
        do_cmd(TRANSFER, 200, 1000);
        do_cmd(BALANCE, 0, 0);
        do_cmd(EXIT, 0, 0);
        do_card(1000);
        do_pin(7);
        do_cmd(BALANCE, 0, 0);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_timeout();
        int seen;
        do_card(2125);
        do_timeout();
        do_card(2125);
        do_pin(3);
        do_timeout();
        do_card(4000);
        do_card(2125);
        do_pin(3);
        seen = 0;
        repeat (TIMEOUT - 1) begin
            step();
            if (rsp_valid) seen++;
        end
        n_total++;
        if (seen !== 0)
            $display("FAIL early timeout: responses=%0d, expected 0", seen);
        else
            n_pass++;
        do_cmd(BALANCE, 0, 0);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_collision();
        int seen;
        prov_we = 1; prov_idx = IDX_W'(2); prov_acc = ACC_W'(3333);
        prov_pin = PIN_W'(5); prov_bal = BAL_W'(42);
        card_valid = 1; acc_num = ACC_W'(3333);
        m_acc[2] = 3333; m_pin[2] = 5; m_bal[2] = 42; m_vld[2] = 1; m_lock[2] = 0; m_tries[2] = 0;
        seen = 0;
        repeat (3) begin
            step();
            clear_strobes();
            if (busy || rsp_valid) seen++;
        end
        n_total++;
        if (seen !== 0)
            $display("FAIL collision: busy/response cycles=%0d, expected 0", seen);
        else
            n_pass++;
        do_card(3333);
        do_pin(5);
        do_cmd(EXIT, 0, 0);
    endtask

    task automatic test_reset_exec();
        do_card(2125);
        do_pin(3);
        cmd_valid = 1; cmd_op = 2'(WITHDRAW); amount = AMT_W'(100);
        step();
        clear_strobes();
        n_total++;
        if (busy !== 1'b1 || session_active !== 1'b1)
            $display("FAIL exec flags: busy=%0b active=%0b, expected 1 1", busy, session_active);
        else
            n_pass++;
        #2 rst_n = 0;
        #1;
        n_total++;
        if ({busy, session_active, rsp_valid, rsp_status, rsp_balance} !== '0)
            $display("FAIL async reset: busy=%0b active=%0b rsp=%0b status=%0d bal=%0d, expected all 0",
                     busy, session_active, rsp_valid, rsp_status, rsp_balance);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        model_reset();
        step();
        do_card(2125);
    endtask

    task automatic test_random();
        int acc, op, k;
        for (int i = 0; i < NUM_ACC; i++)
            prov(i, 100 + int'($urandom % 10), int'($urandom % 4),
                 ($urandom % 2) ? 65535 - int'($urandom_range(0, 2999)) : int'($urandom_range(0, 4999)));
        for (int s = 0; s < 40; s++) begin
            if ($urandom % 3 == 0)
                prov(int'($urandom % NUM_ACC), 100 + int'($urandom % 10), int'($urandom % 4),
                     ($urandom % 2) ? 65535 - int'($urandom_range(0, 2999)) : int'($urandom_range(0, 4999)));
            acc = 100 + int'($urandom % 12);
            do_card(acc);
            k = 0;
            while (m_phase == 1 && k < 4) begin
                do_pin(int'($urandom % 4));
                k++;
            end
            if (m_phase == 1) do_timeout();
            if (m_phase == 2) begin
                repeat (int'($urandom % 6)) begin
                    op = int'($urandom % 3);
                    do_cmd(op, int'($urandom % 2048), 100 + int'($urandom % 12));
                end
                do_cmd(EXIT, 0, 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_login_balance();
        test_lockout();
        test_withdraw();
        test_transfer();
        test_timeout();
        test_collision();
        test_reset_exec();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised, fully synchronous ATM session controller: next-generation replacement for the combinational-lookup ATM front end. Holds a provisionable table of NUM_ACC accounts, each with a number, PIN, balance and lock state. Runs one customer session at a time: card lookup, PIN check with retry lockout, then balance, withdraw, transfer and exit commands, with an inactivity timeout. It sits between the keypad/card front end and the display/cash-dispense logic, and reports every outcome through a single-cycle response strobe.

## Interface
- NUM_ACC, 10: number of account table entries (at least 2).
- ACC_W, 12: account number width.
- PIN_W, 4: PIN width.
- BAL_W, 16: balance width, unsigned.
- AMT_W, 11: transaction amount width, AMT_W ≤ BAL_W.
- MAX_TRIES, 3: consecutive wrong PINs that lock an account.
- TIMEOUT, 255: idle cycles allowed in PIN_WAIT/MENU.
- clk  in  1  the single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- prov_we  in  1  provisioning write strobe; honoured only in IDLE.
- prov_idx  in  clog2(NUM_ACC)  table entry to write.
- prov_acc / prov_pin / prov_bal  in  ACC_W / PIN_W / BAL_W  entry contents.
- card_valid  in  1  start a session for acc_num (IDLE only).
- acc_num  in  ACC_W  card account number.
- pin_valid  in  1  PIN entry strobe (PIN_WAIT only).
- pin  in  PIN_W  entered PIN.
- cmd_valid  in  1  command strobe (MENU only).
- cmd_op  in  2  0 BALANCE, 1 WITHDRAW, 2 TRANSFER, 3 EXIT.
- amount  in  AMT_W  withdraw/transfer amount.
- dest_acc  in  ACC_W  transfer destination account number.
- busy  out  1  high in SCAN, SCAN_DEST and EXEC.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  3  0 OK, 1 NO_ACC, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 NO_DEST, 6 OVERFLOW, 7 TIMEOUT.
- rsp_balance  out  BAL_W  session account balance after the operation; 0 on failures before login.
- session_active  out  1  high in MENU, SCAN_DEST and EXEC.

## Operation
- **Reset.** All outputs are 0. State goes to IDLE. All entry valid bits, lock bits and try counters clear. Table contents are don't-care until provisioned.
- **IDLE**
  - prov_we writes the entry, sets its valid bit, clears its lock bit and try counter.
  - Otherwise card_valid latches acc_num, clears the scan index and moves to SCAN.
  - If both are high, prov_we wins and card_valid is ignored.
- **SCAN**
  - Examines one entry per cycle, index 0 upward; only valid entries can match.
  - On a match: if the entry is locked, respond LOCKED and go to IDLE; otherwise record cur_idx and go to PIN_WAIT.
  - After index NUM_ACC-1 with no match: respond NO_ACC and go to IDLE.
  - For duplicate account numbers, the lowest index wins.
- **PIN_WAIT**
  - A matching pin_valid clears the try counter and responds OK with the balance, then goes to MENU.
  - A mismatched pin_valid increments the try counter. If the counter reaches MAX_TRIES: set the lock bit, respond LOCKED, go to IDLE. Otherwise respond BAD_PIN and stay.
  - The try counter persists across sessions until a correct PIN or a provisioning write.
- **MENU**, on cmd_valid:
  - BALANCE: respond OK with the balance.
  - WITHDRAW: go to EXEC.
  - TRANSFER: latch dest_acc and amount, go to SCAN_DEST.
  - EXIT: respond OK with the balance, go to IDLE.
- **SCAN_DEST**
  - Same scan as SCAN; lock state is ignored.
  - No match, or match equal to cur_idx: respond NO_DEST, go to MENU.
  - Match: record dest_idx and go to EXEC.
- **EXEC**, one cycle, then back to MENU with a response:
  - Any operation with amount > own balance: respond INSUFF, no change.
  - TRANSFER where dest balance + amount > 2^BAL_W−1 (checked in BAL_W+1 bits): respond OVERFLOW, no change.
  - Otherwise debit own balance, credit dest for TRANSFER, and respond OK with the new own balance.
  - amount = 0 is legal and responds OK.
- **Timeout.** A counter is cleared on entry to PIN_WAIT/MENU and on every accepted pin_valid/cmd_valid. When it reaches TIMEOUT: respond TIMEOUT and go to IDLE. The try counter is unaffected.
- **Ignored strobes.** Any strobe that is not legal in the current state is ignored, with no response.

## Timing
- Inputs are sampled at the rising edge. Every response is registered, so rsp_valid is high for exactly one cycle.
- **Card lookup.** card_valid at edge E; a match at index i enters PIN_WAIT at edge E+i+1. A NO_ACC response is visible after edge E+NUM_ACC.
- **PIN.** pin_valid at edge E gives its response after edge E (1-cycle latency).
- **Commands**
  - BALANCE/EXIT: 1-cycle latency.
  - WITHDRAW: 2 cycles (MENU→EXEC→MENU).
  - TRANSFER with destination at index j: j+3 cycles.
- **Timeout.** Fires TIMEOUT cycles after the last accepted strobe or state entry. A strobe arriving on the expiry cycle takes priority over the timeout.
- **Async reset.** rst_n low mid-operation aborts immediately, with no partial balance update.

## Test plan
- **Login and balance.** Provision idx 3 = {2125, pin 3, bal 500}. Card 2125 enters PIN_WAIT 4 cycles after card_valid; pin 3 → OK with balance 500; BALANCE → OK with 500.
- **Lockout.** On idx 3, three wrong PINs → BAD_PIN, BAD_PIN, LOCKED, then IDLE. A new card 2125 → LOCKED. Re-provisioning idx 3 clears the lock and login succeeds.
- **Withdraw limits.** Balance 500: withdraw 500 → OK with 0. Withdraw 1 → INSUFF with balance still 0. Withdraw 0 → OK.
- **Transfer.** Dest balance 65000, amount 600 → OVERFLOW with no change. Transfer to own account → NO_DEST. Transfer to 9999 → NO_DEST. Valid transfer of 200 → own balance −200, dest balance +200, OK.
- **Timeout and unknown card.** Idle TIMEOUT cycles in MENU → TIMEOUT then IDLE. Card 4000 → NO_ACC after NUM_ACC cycles.
- **Reset and collisions.** rst_n asserted in EXEC → outputs 0 and balance unchanged. Simultaneous prov_we and card_valid in IDLE → write done and no session started.
